// File: rtl/i2s_sample_rx_pkg.sv
// ----------------------------------------------------------------------------
// i2s_sample_rx_pkg
// Shared audio definitions used by the I2S receiver and the effects pipeline:
//   - DEFAULT_SAMPLE_WIDTH : default width of one audio sample (16)
//   - ST_* constants       : receiver state encodings (legacy-compatible)
//   - rx_state_e           : receiver state type built on the ST_* encodings
//   - slot_level()         : lrclk level that selects a given channel
// ----------------------------------------------------------------------------
package i2s_sample_rx_pkg;

    localparam int DEFAULT_SAMPLE_WIDTH = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARM   = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ARM   = ST_ARM,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } rx_state_e;

    // Left slot is lrclk low, right slot is lrclk high.
    function automatic logic slot_level(input int channel);
        return (channel != 0);
    endfunction

endpackage

// File: rtl/i2s_sample_rx_sync2.sv
// ----------------------------------------------------------------------------
// sync2
// Two-flop synchronizer for a single asynchronous input bit.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears both flops
//   d     : asynchronous input
//   q     : synchronized output (2 clk latency)
// ----------------------------------------------------------------------------
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/i2s_sample_rx.sv
// ----------------------------------------------------------------------------
// i2s_sample_rx
// Captures one channel of an I2S stream into parallel two's-complement
// samples, oversampling bclk/lrclk/sdata with the system clock.
//
// Parameters
//   SAMPLE_WIDTH : bits captured per sample (MSB first)
//   CHANNEL      : 0 = left slot (lrclk low), 1 = right slot (lrclk high)
// Ports
//   clk          : system clock, at least 4x bclk
//   rst_n        : asynchronous active-low reset
//   bclk         : I2S bit clock (asynchronous)
//   lrclk        : I2S word select (asynchronous)
//   sdata        : I2S serial data (asynchronous)
//   sample       : last complete sample, held between updates
//   sample_valid : one-clk pulse when sample updates
//   frame_error  : one-clk pulse when the slot ends before a full word
//
// State   | meaning
// --------+------------------------------------------------------------------
// IDLE    | not aligned; wait for lrclk to move to the channel level
// ARM     | slot start seen; the delay bit was on that rise, clear counter
// SHIFT   | shifting sdata in on each bclk rise
// DONE    | word captured; ignore slot padding until the next slot start
// ----------------------------------------------------------------------------
module i2s_sample_rx
    import i2s_sample_rx_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH,
    parameter int CHANNEL      = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    bclk,
    input  logic                    lrclk,
    input  logic                    sdata,
    output logic [SAMPLE_WIDTH-1:0] sample,
    output logic                    sample_valid,
    output logic                    frame_error
);

    localparam int               CNT_W    = $clog2(SAMPLE_WIDTH + 1);
    localparam logic             SLOT_LVL = slot_level(CHANNEL);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SAMPLE_WIDTH - 1);

    logic                    bclk_s;
    logic                    lrclk_s;
    logic                    sdata_s;
    logic                    bclk_prev;
    logic                    lrclk_prev;
    logic                    lr_primed;
    logic                    load_pend;
    rx_state_e               state;
    logic [SAMPLE_WIDTH-1:0] shift_q;
    logic [CNT_W-1:0]        bit_cnt;

    logic                    rise;
    logic                    in_slot;
    logic                    slot_start;
    logic [SAMPLE_WIDTH-1:0] shift_next;

    sync2 u_sync_bclk  (.clk(clk), .rst_n(rst_n), .d(bclk),  .q(bclk_s));
    sync2 u_sync_lrclk (.clk(clk), .rst_n(rst_n), .d(lrclk), .q(lrclk_s));
    sync2 u_sync_sdata (.clk(clk), .rst_n(rst_n), .d(sdata), .q(sdata_s));

    assign rise       = bclk_s & ~bclk_prev;
    assign in_slot    = (lrclk_s == SLOT_LVL);
    // lrclk_prev means nothing until one rise has loaded it after reset;
    // without lr_primed a reset released mid-slot could look like a slot start.
    assign slot_start = rise & lr_primed & in_slot & (lrclk_prev != SLOT_LVL);
    assign shift_next = {shift_q[SAMPLE_WIDTH-2:0], sdata_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_prev    <= 1'b0;
            lrclk_prev   <= 1'b0;
            lr_primed    <= 1'b0;
            load_pend    <= 1'b0;
            state        <= IDLE;
            shift_q      <= '0;
            bit_cnt      <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            bclk_prev    <= bclk_s;
            sample_valid <= 1'b0;
            frame_error  <= 1'b0;
            load_pend    <= 1'b0;

            if (rise) begin
                lrclk_prev <= lrclk_s;
                lr_primed  <= 1'b1;
            end

            // Publish the finished word on the clk after its last bit.
            if (load_pend) begin
                sample       <= shift_q;
                sample_valid <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (slot_start) begin
                        state <= ARM;
                    end
                end

                // The rise that showed the new lrclk level carried the
                // previous word's LSB (the I2S one-bit delay), so ARM only
                // clears the datapath; the next rise carries the MSB.
                ARM: begin
                    state   <= SHIFT;
                    bit_cnt <= '0;
                    shift_q <= '0;
                end

                // The final bit of a full-width slot arrives on the rise
                // where lrclk has already moved on, so completion is tested
                // before the slot-ended check.
                SHIFT: begin
                    if (rise) begin
                        if (bit_cnt == LAST_BIT) begin
                            shift_q   <= shift_next;
                            bit_cnt   <= bit_cnt + 1'b1;
                            load_pend <= 1'b1;
                            state     <= DONE;
                        end else if (!in_slot) begin
                            frame_error <= 1'b1;
                            state       <= IDLE;
                        end else if (slot_start) begin
                            state <= ARM;
                        end else begin
                            shift_q <= shift_next;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end

                DONE: begin
                    if (slot_start) begin
                        state <= ARM;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_sample_rx.sv
module tb_i2s_sample_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic [15:0] sample0;
    logic [15:0] sample1;
    logic        vld0;
    logic        vld1;
    logic        err0;
    logic        err1;

    int checks;
    int errors;
    int err_cnt0;
    int err_cnt1;
    int half_ns;
    logic carry;

    logic [15:0] q0[$];
    logic [15:0] q1[$];

    typedef struct {
        logic [15:0] left;
        logic [15:0] right;
        int          slot;
        logic        pad;
        logic [15:0] out0;
        logic [15:0] out1;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs[NV];

    always #5 clk = ~clk;

    i2s_sample_rx #(.SAMPLE_WIDTH(16), .CHANNEL(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
        .sample(sample0), .sample_valid(vld0), .frame_error(err0)
    );

    i2s_sample_rx #(.SAMPLE_WIDTH(16), .CHANNEL(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
        .sample(sample1), .sample_valid(vld1), .frame_error(err1)
    );

    task automatic check(input bit ok, input string name,
                         input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Scoreboard consumer: every valid pops the next expected word.
    task automatic monitor();
        logic        pv0, pv1, pe0, pe1;
        logic [15:0] e;
        pv0 = 1'b0; pv1 = 1'b0; pe0 = 1'b0; pe1 = 1'b0;
        forever begin
            @(negedge clk);
            if (vld0) begin
                check(q0.size() != 0, "sb0_has_expected", sample0, 0);
                if (q0.size() != 0) begin
                    e = q0.pop_front();
                    check(sample0 === e, "sb0_word", sample0, e);
                end
                check(!pv0 && !err0, "valid0_pulse", {pv0, err0}, 0);
            end
            if (vld1) begin
                check(q1.size() != 0, "sb1_has_expected", sample1, 0);
                if (q1.size() != 0) begin
                    e = q1.pop_front();
                    check(sample1 === e, "sb1_word", sample1, e);
                end
                check(!pv1 && !err1, "valid1_pulse", {pv1, err1}, 0);
            end
            if (err0) begin
                err_cnt0++;
                check(!pe0, "err0_pulse", pe0, 0);
            end
            if (err1) begin
                err_cnt1++;
                check(!pe1, "err1_pulse", pe1, 0);
            end
            pv0 = vld0; pv1 = vld1; pe0 = err0; pe1 = err1;
        end
    endtask

    function automatic logic stream_bit(input logic [15:0] w, input logic pad, input int k);
        return (k < 16) ? w[15-k] : pad;
    endfunction

    // lrclk and sdata change on the falling bclk edge.
    task automatic send_bit(input logic lr, input logic d);
        bclk  = 1'b0;
        lrclk = lr;
        sdata = d;
        #(half_ns);
        bclk  = 1'b1;
        #(half_ns);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check(sample0 === 16'h0, "rst_mid_sample0", sample0, 0);
        check(sample1 === 16'h0, "rst_mid_sample1", sample1, 0);
        check(vld0 === 1'b0 && err0 === 1'b0, "rst_mid_flags0", {vld0, err0}, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One slot: first bit is the previous slot's last bit (I2S delay).
    task automatic send_slot(input logic lr, input logic [15:0] word, input int nbits,
                             input logic pad, input int rst_at);
        for (int j = 0; j < nbits; j++) begin
            if (j == rst_at) pulse_reset();
            send_bit(lr, (j == 0) ? carry : stream_bit(word, pad, j - 1));
        end
        carry = stream_bit(word, pad, nbits - 1);
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                              input int slot, input logic pad);
        send_slot(1'b0, l, slot, pad, -1);
        send_slot(1'b1, r, slot, pad, -1);
    endtask

    initial begin
        logic [15:0] wl, wr;
        rst_n   = 1'b0;
        bclk    = 1'b0;
        lrclk   = 1'b1;
        sdata   = 1'b0;
        carry   = 1'b0;
        half_ns = 40;
        checks  = 0;
        errors  = 0;
        err_cnt0 = 0;
        err_cnt1 = 0;

        vecs[0] = '{16'h8001, 16'h0F0F, 24, 1'b0, 16'h8001, 16'h0F0F};
        vecs[1] = '{16'h8001, 16'h4242, 24, 1'b0, 16'h8001, 16'h4242};
        vecs[2] = '{16'h1234, 16'h7FFF, 16, 1'b0, 16'h1234, 16'h7FFF};
        vecs[3] = '{16'h1234, 16'h7FFF, 16, 1'b1, 16'h1234, 16'h7FFF};
        vecs[4] = '{16'hA5A5, 16'h5A5A, 32, 1'b1, 16'hA5A5, 16'h5A5A};
        vecs[5] = '{16'h0000, 16'hFFFF, 32, 1'b0, 16'h0000, 16'hFFFF};
        vecs[6] = '{16'hFFFF, 16'h0001, 16, 1'b1, 16'hFFFF, 16'h0001};
        vecs[7] = '{16'h7FFF, 16'h8000, 24, 1'b1, 16'h7FFF, 16'h8000};

        fork
            monitor();
        join_none

        repeat (4) @(negedge clk);
        check(sample0 === 16'h0, "rst_sample0", sample0, 0);
        check(sample1 === 16'h0, "rst_sample1", sample1, 0);
        check(vld0 === 1'b0, "rst_valid0", vld0, 0);
        check(vld1 === 1'b0, "rst_valid1", vld1, 0);
        check(err0 === 1'b0, "rst_err0", err0, 0);
        check(err1 === 1'b0, "rst_err1", err1, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);

        for (int i = 0; i < NV; i++) begin
            q0.push_back(vecs[i].out0);
            q1.push_back(vecs[i].out1);
            send_frame(vecs[i].left, vecs[i].right, vecs[i].slot, vecs[i].pad);
            check(sample0 === vecs[i].out0, "vec_sample0", sample0, vecs[i].out0);
        end

        // Left slot cut short after 10 bits.
        q1.push_back(16'h6C6C);
        send_slot(1'b0, 16'hC3C3, 10, 1'b0, -1);
        send_slot(1'b1, 16'h6C6C, 16, 1'b0, -1);
        check(err_cnt0 == 1, "short_slot_err0", err_cnt0, 1);
        check(err_cnt1 == 0, "short_slot_err1", err_cnt1, 0);
        check(sample0 === vecs[NV-1].out0, "short_slot_hold", sample0, vecs[NV-1].out0);

        q0.push_back(16'h0BAD);
        q1.push_back(16'h600D);
        send_frame(16'h0BAD, 16'h600D, 16, 1'b0);
        check(sample0 === 16'h0BAD, "recover_sample0", sample0, 16'h0BAD);

        // Reset mid left slot: that left word is lost, the right one is not.
        q1.push_back(16'h1357);
        send_slot(1'b0, 16'hBEEF, 16, 1'b0, 5);
        send_slot(1'b1, 16'h1357, 16, 1'b0, -1);
        check(sample0 === 16'h0, "post_rst_no_valid0", sample0, 0);
        q0.push_back(16'h2468);
        q1.push_back(16'h9ABC);
        send_frame(16'h2468, 16'h9ABC, 16, 1'b0);
        check(sample0 === 16'h2468, "post_rst_first0", sample0, 16'h2468);

        // clk = 4x bclk with a random bclk phase, 1000 words over both channels.
        half_ns = 20;
        for (int f = 0; f < 500; f++) begin
            if (f % 50 == 0) begin
                @(posedge clk);
                #($urandom_range(1, 9));
            end
            wl = 16'($urandom());
            wr = 16'($urandom());
            q0.push_back(wl);
            q1.push_back(wr);
            send_frame(wl, wr, 16, 1'b0);
        end

        // One more bit delivers the last right word's LSB.
        send_slot(1'b0, 16'h0000, 1, 1'b0, -1);
        repeat (10) @(negedge clk);

        check(q0.size() == 0, "sb0_drained", q0.size(), 0);
        check(q1.size() == 0, "sb1_drained", q1.size(), 0);
        check(err_cnt0 == 1, "final_err0", err_cnt0, 1);
        check(err_cnt1 == 0, "final_err1", err_cnt1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
